jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//   Shares one bank of WIDTH edge-triggered JK flip-flops between two requesters.
//   Each requester issues a masked command (HOLD/CLEAR/SET/TOGGLE) over a valid/ready handshake.
//   A round-robin arbiter grants one requester at a time, and an FSM sequences the J/K drive into the bank.
//   A done pulse reports completion. The block sits between the control logic and the JK storage bank.
// PARAMETERS
//   WIDTH  8  number of JK flip-flops in the shared bank
// PORTS
//   clk         in   1      system clock, rising-edge active
//   rst_n       in   1      reset, asynchronous assert, active-low
//   req0_valid  in   1      requester 0 has a command pending
//   req0_op     in   2      requester 0 opcode
//   req0_mask   in   WIDTH  requester 0 bit-select (1 = bit is affected)
//   req0_ready  out  1      requester 0 command accepted this cycle
//   req1_valid  in   1      requester 1 has a command pending
//   req1_op     in   2      requester 1 opcode
//   req1_mask   in   WIDTH  requester 1 bit-select
//   req1_ready  out  1      requester 1 command accepted this cycle
//   q           out  WIDTH  current bank contents
//   done        out  1      one-cycle pulse: the granted command has been applied
//   grant_id    out  1      requester whose command completed; valid while done=1
// BEHAVIOUR
//   Clocking and reset:
//   - One clock domain. rst_n low asynchronously forces: q=0, state=IDLE, done=0, grant_id=0,
//     req*_ready=0, rr_last=1 (requester 0 wins the first tie).
//   Opcodes, per masked bit {j,k}:
//   - 00 HOLD {0,0}, 01 CLEAR {0,1}, 10 SET {1,0}, 11 TOGGLE {1,1}.
//   - Unmasked bits always get {0,0}, so they hold their value.
//   FSM states: IDLE -> APPLY -> DONE -> IDLE.
//   - IDLE:
//     - If any valid is high, pick a winner: if only one valid, that one; if both, the one != rr_last.
//     - reqX_ready=1 (combinational) for the winner only. The handshake completes on that edge.
//     - Latch op, mask and id; set rr_last=id; go to APPLY.
//     - If no valid, stay in IDLE with all ready=0.
//   - APPLY: drive the bank J/K from the latched command. The bank updates on the next edge; go to DONE.
//   - DONE: done=1, grant_id=latched id; q already shows the new value. Go to IDLE on the next edge.
//   - ready is never high outside IDLE, and never high for both requesters at once.
//   Latency and throughput:
//   - Accept edge E0 -> q updated at E1 -> done high in the cycle after E1.
//   - One command per 3 cycles maximum.
//   - Back-to-back: both valid held high -> grants alternate 0,1,0,1.
//   Data and reset rules:
//   - The latched command is immune to requester input changes after acceptance.
//   - Requesters hold valid/op/mask stable until ready. Valid dropped before ready means no command.
//   - rst_n asserted in APPLY or DONE aborts the command: no done, q=0. Operation resumes from IDLE.
//   - Mask of all zeros is legal: the full handshake and done pulse occur, and q is unchanged.
//   - TOGGLE on the same bit twice restores it. No width growth; each bit is independent.
// STRUCTURE
//   - jk_ctrl_pkg: opcode localparams (OP_HOLD/OP_CLEAR/OP_SET/OP_TOGGLE) and FSM state encoding
//     (ST_IDLE/ST_APPLY/ST_DONE).
//   - Sub-module jk_ff_cell (j, k, clk, rst_n, out): one edge-triggered JK flip-flop with async
//     active-low clear. Instantiate it WIDTH times in a generate loop.
//   - Arbiter, latch and FSM live in this module.
// TESTING
//   - Reset: rst_n=0 mid-run -> q=0, done=0, ready=0 immediately, without waiting for clk.
//   - Single request:
//     - req0 SET mask=8'h0F -> req0_ready 1 cycle; q=8'h0F at E1; done=1, grant_id=0 next cycle.
//     - Then req0 CLEAR mask=8'h03 -> q=8'h0C.
//   - Contention: both valid from reset, req0 SET 8'hF0, req1 TOGGLE 8'hFF, held high ->
//     - grants in order 0,1,0,1;
//     - q sequence F0, 0F, FF, 00;
//     - never both ready high.
//   - Opcode sweep on mask 8'h01: HOLD, CLEAR, SET, TOGGLE, SET, CLEAR, HOLD from q=0 ->
//     q[0] = 0, 0, 1, 0, 1, 0, 0.
//   - Abort: assert rst_n=0 during APPLY of SET 8'hFF -> no done pulse, q stays 8'h00.
//   - Input stability: change req1_op/mask right after acceptance -> the applied result matches
//     the latched command.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared opcode and FSM encodings for the JK bank arbiter.
// The two opcode bits map directly onto {j,k} for every masked bit.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       id;
  } cmd_t;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester handshakes plus bank status for the JK bank arbiter.
interface jk_bank_arbiter_if #(parameter int WIDTH = 8) ();
  logic             req0_valid;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_mask;
  logic             req0_ready;
  logic             req1_valid;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_mask;
  logic             req1_ready;
  logic [WIDTH-1:0] q;
  logic             done;
  logic             grant_id;

  modport slave (
    input  req0_valid, req0_op, req0_mask,
    input  req1_valid, req1_op, req1_mask,
    output req0_ready, req1_ready, q, done, grant_id
  );

  modport master (
    output req0_valid, req0_op, req0_mask,
    output req1_valid, req1_op, req1_mask,
    input  req0_ready, req1_ready, q, done, grant_id
  );
endinterface

// File: rtl/jk_ff_cell.sv
// One edge-triggered JK flip-flop with asynchronous active-low clear.
module jk_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   out <= 1'b0;
        2'b10:   out <= 1'b1;
        2'b11:   out <= ~out;
        default: out <= out;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a WIDTH-bit JK flip-flop bank between two requesters.
// IDLE accepts one command, APPLY drives J/K for one edge, DONE pulses completion.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  jk_bank_arbiter_if.slave   bus
);

  state_t           state, state_nxt;
  cmd_t             cmd;
  logic [WIDTH-1:0] mask;
  logic             rr_last;
  logic             any_valid;
  logic             win_id;
  logic             accept;
  logic [WIDTH-1:0] j_drv, k_drv;
  logic [WIDTH-1:0] q_bank;

  // On a tie the requester that did not win last time gets the bank.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign win_id    = (bus.req0_valid & bus.req1_valid) ? ~rr_last : bus.req1_valid;
  assign accept    = (state == ST_IDLE) & any_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_valid) state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.done       = 1'b0;
    bus.grant_id   = 1'b0;
    j_drv          = '0;
    k_drv          = '0;
    case (state)
      ST_IDLE: begin
        // Gated by rst_n so ready drops the instant reset asserts.
        bus.req0_ready = rst_n & accept & ~win_id;
        bus.req1_ready = rst_n & accept &  win_id;
      end
      ST_APPLY: begin
        j_drv = mask & {WIDTH{cmd.op[1]}};
        k_drv = mask & {WIDTH{cmd.op[0]}};
      end
      ST_DONE: begin
        bus.done     = 1'b1;
        bus.grant_id = cmd.id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      mask    <= '0;
      rr_last <= 1'b1;
    end else if (accept) begin
      cmd.op  <= win_id ? bus.req1_op   : bus.req0_op;
      cmd.id  <= win_id;
      mask    <= win_id ? bus.req1_mask : bus.req0_mask;
      rr_last <= win_id;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_drv[i]),
      .k     (k_drv[i]),
      .out   (q_bank[i])
    );
  end

  assign bus.q = q_bank;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: reset, single commands, contention, opcode sweep, abort.
module tb_jk_bank_arbiter;
  import jk_ctrl_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.WIDTH(WIDTH)) bus ();

  jk_bank_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Issue one command from IDLE and follow it through APPLY and DONE.
  task automatic do_cmd(input string tag, input logic id, input logic [1:0] op,
                        input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp_q);
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_mask = m;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_mask = m;
    end
    #1;
    chk({tag, " ready_win"},  id ? bus.req1_ready : bus.req0_ready, 1);
    chk({tag, " ready_lose"}, id ? bus.req0_ready : bus.req1_ready, 0);
    tick();
    drop_valid();
    #1;
    chk({tag, " apply_ready"}, {bus.req0_ready, bus.req1_ready}, 0);
    chk({tag, " apply_done"},  bus.done, 0);
    tick();
    chk({tag, " q"},     bus.q, exp_q);
    chk({tag, " done"},  bus.done, 1);
    chk({tag, " grant"}, bus.grant_id, id);
    tick();
    chk({tag, " done_clr"}, bus.done, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] cont_q [4];
    logic             sweep_q [7];
    logic [1:0]       sweep_op [7];
    cont_q   = '{8'hF0, 8'h0F, 8'hFF, 8'h00};
    sweep_op = '{OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE, OP_SET, OP_CLEAR, OP_HOLD};
    sweep_q  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset with a requester already valid: ready must stay low.
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = OP_SET; bus.req0_mask = 8'hFF;
    bus.req1_valid = 1'b0; bus.req1_op = OP_HOLD; bus.req1_mask = 8'h00;
    #12;
    chk("rst q", bus.q, 0);
    chk("rst done", bus.done, 0);
    chk("rst grant", bus.grant_id, 0);
    chk("rst ready", {bus.req0_ready, bus.req1_ready}, 0);
    drop_valid();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle noready", {bus.req0_ready, bus.req1_ready}, 0);

    do_cmd("set0F", 1'b0, OP_SET,   8'h0F, 8'h0F);
    do_cmd("clr03", 1'b0, OP_CLEAR, 8'h03, 8'h0C);

    // Contention from a fresh reset, both requesters held valid.
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst2 q", bus.q, 0);
    @(negedge clk); rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_SET;    bus.req0_mask = 8'hF0;
    bus.req1_valid = 1'b1; bus.req1_op = OP_TOGGLE; bus.req1_mask = 8'hFF;
    #1;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("cont%0d ready", n), {bus.req1_ready, bus.req0_ready},
          (n % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("cont%0d apply_ready", n), {bus.req0_ready, bus.req1_ready}, 0);
      tick();
      chk($sformatf("cont%0d q", n), bus.q, cont_q[n]);
      chk($sformatf("cont%0d done", n), bus.done, 1);
      chk($sformatf("cont%0d grant", n), bus.grant_id, n % 2);
      tick();
    end
    drop_valid();

    for (int n = 0; n < 7; n++)
      do_cmd($sformatf("sweep%0d", n), 1'b0, sweep_op[n], 8'h01, {7'b0, sweep_q[n]});

    do_cmd("setAA",   1'b1, OP_SET,    8'hAA, 8'hAA);
    do_cmd("mask0",   1'b0, OP_TOGGLE, 8'h00, 8'hAA);
    do_cmd("tog3C_a", 1'b1, OP_TOGGLE, 8'h3C, 8'h96);
    do_cmd("tog3C_b", 1'b0, OP_TOGGLE, 8'h3C, 8'hAA);

    // Abort: reset lands mid-APPLY, before the bank edge.
    bus.req0_valid = 1'b1; bus.req0_op = OP_SET; bus.req0_mask = 8'hFF;
    tick();
    drop_valid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort q", bus.q, 0);
    chk("abort done", bus.done, 0);
    chk("abort ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort q1", bus.q, 0);
    chk("abort done1", bus.done, 0);
    tick();
    chk("abort q2", bus.q, 0);
    chk("abort done2", bus.done, 0);

    // Requester changes its inputs right after acceptance.
    bus.req1_valid = 1'b1; bus.req1_op = OP_TOGGLE; bus.req1_mask = 8'h0F;
    #1;
    chk("stab ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0; bus.req1_op = OP_SET; bus.req1_mask = 8'hF0;
    tick();
    chk("stab q", bus.q, 8'h0F);
    chk("stab done", bus.done, 1);
    chk("stab grant", bus.grant_id, 1);
    tick();
    chk("stab idle", bus.done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
